// File: rtl/imu_sync_pkg.sv
// Shared types and constants for the IMU sample-to-FIFO packetiser.
// A packet is three 64-bit words: header, accel, gyro.
package imu_sync_pkg;

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned AXIS_W   = 16;
    localparam int unsigned SEQ_W    = 8;
    localparam int unsigned HDR_TS_W = 48;

    localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_HDR = 2'd1,
        WR_ACC = 2'd2,
        WR_GYR = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        WORD_NONE = 2'd0,
        WORD_HDR  = 2'd1,
        WORD_ACC  = 2'd2,
        WORD_GYR  = 2'd3
    } word_type_e;

    typedef struct packed {
        logic signed [AXIS_W-1:0] x;
        logic signed [AXIS_W-1:0] y;
        logic signed [AXIS_W-1:0] z;
    } axis3_t;

    typedef struct packed {
        axis3_t accel;
        axis3_t gyro;
    } imu_sample_t;

    function automatic word_type_e word_type_of(input wr_state_e s);
        word_type_e t;
        t = WORD_NONE;
        case (s)
            WR_HDR:  t = WORD_HDR;
            WR_ACC:  t = WORD_ACC;
            WR_GYR:  t = WORD_GYR;
            default: t = WORD_NONE;
        endcase
        return t;
    endfunction

    // Three axes packed high-to-low, low 16 bits reserved as zero
    function automatic logic [WORD_W-1:0] axis_word(input axis3_t a);
        return {a.x, a.y, a.z, 16'h0000};
    endfunction

endpackage

// File: rtl/imu_timestamp_counter.sv
// Free-running timestamp counter, wraps from all-ones to zero.
module imu_timestamp_counter #(
    parameter int unsigned TS_WIDTH = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [TS_WIDTH-1:0] ts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/imu_fifo_writer.sv
// Captures an IMU sample with a timestamp and writes it to a 64-bit FIFO as a
// three-word packet; samples arriving while a packet is in flight are counted as drops.
module imu_fifo_writer
    import imu_sync_pkg::*;
#(
    parameter int unsigned TS_WIDTH = 48,
    parameter logic [7:0]  HDR_TAG  = HDR_TAG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     imu_valid,
    input  logic signed [AXIS_W-1:0] imu_accel_x,
    input  logic signed [AXIS_W-1:0] imu_accel_y,
    input  logic signed [AXIS_W-1:0] imu_accel_z,
    input  logic signed [AXIS_W-1:0] imu_gyro_x,
    input  logic signed [AXIS_W-1:0] imu_gyro_y,
    input  logic signed [AXIS_W-1:0] imu_gyro_z,
    input  logic                     fifo_full,
    input  logic                     clr_drop,
    output logic                     fifo_wr_en,
    output logic [WORD_W-1:0]        fifo_data_in,
    output logic                     busy,
    output logic [SEQ_W-1:0]         seq_num,
    output logic [15:0]              drop_count
);

    wr_state_e             state_q;
    wr_state_e             state_d;
    word_type_e            word_type;
    imu_sample_t           sample_q;
    logic [HDR_TS_W-1:0]   ts_cap_q;
    logic [TS_WIDTH-1:0]   ts;
    logic                  accept;
    logic                  drop;

    imu_timestamp_counter #(
        .TS_WIDTH (TS_WIDTH)
    ) u_ts (
        .clk   (clk),
        .rst_n (rst_n),
        .ts    (ts)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO write port; the write word is a pure function of state and captures
    always_comb begin
        state_d      = state_q;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        accept       = 1'b0;
        drop         = 1'b0;
        word_type    = word_type_of(state_q);

        case (word_type)
            WORD_HDR: fifo_data_in = {HDR_TAG, seq_num, ts_cap_q};
            WORD_ACC: fifo_data_in = axis_word(sample_q.accel);
            WORD_GYR: fifo_data_in = axis_word(sample_q.gyro);
            default:  fifo_data_in = '0;
        endcase

        fifo_wr_en = (word_type != WORD_NONE) && !fifo_full;

        case (state_q)
            IDLE: begin
                if (imu_valid) begin
                    accept  = 1'b1;
                    state_d = WR_HDR;
                end
            end
            WR_HDR: begin
                drop = imu_valid;
                if (!fifo_full) state_d = WR_ACC;
            end
            WR_ACC: begin
                drop = imu_valid;
                if (!fifo_full) state_d = WR_GYR;
            end
            WR_GYR: begin
                drop = imu_valid;
                if (!fifo_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            ts_cap_q <= '0;
            seq_num  <= '0;
        end else if (accept) begin
            sample_q <= {imu_accel_x, imu_accel_y, imu_accel_z,
                         imu_gyro_x, imu_gyro_y, imu_gyro_z};
            ts_cap_q <= HDR_TS_W'(ts);
            seq_num  <= seq_num + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
        end
    end

    // Clear has priority over a coincident drop; count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (clr_drop) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_imu_fifo_writer.sv
// Directed plus randomized checks of imu_fifo_writer against a packet-queue reference model.
module tb_imu_fifo_writer;

    logic               clk;
    logic               rst_n;
    logic               imu_valid;
    logic signed [15:0] imu_accel_x, imu_accel_y, imu_accel_z;
    logic signed [15:0] imu_gyro_x, imu_gyro_y, imu_gyro_z;
    logic               fifo_full;
    logic               clr_drop;
    logic               fifo_wr_en;
    logic [63:0]        fifo_data_in;
    logic               busy;
    logic [7:0]         seq_num;
    logic [15:0]        drop_count;

    imu_fifo_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imu_valid    (imu_valid),
        .imu_accel_x  (imu_accel_x),
        .imu_accel_y  (imu_accel_y),
        .imu_accel_z  (imu_accel_z),
        .imu_gyro_x   (imu_gyro_x),
        .imu_gyro_y   (imu_gyro_y),
        .imu_gyro_z   (imu_gyro_z),
        .fifo_full    (fifo_full),
        .clr_drop     (clr_drop),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy),
        .seq_num      (seq_num),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned dut_writes  = 0;

    // Reference model: outstanding packet words, cycle-count timestamp, seq and drops
    logic [63:0] exp_q[$];
    logic [7:0]  mseq;
    logic [15:0] mdrop;
    logic [47:0] mts;
    logic [15:0] s[6];
    bit          rand_samp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic c);
        if (rand_samp) foreach (s[i]) s[i] = 16'($urandom);
        imu_valid   = v;
        fifo_full   = f;
        clr_drop    = c;
        imu_accel_x = s[0];
        imu_accel_y = s[1];
        imu_accel_z = s[2];
        imu_gyro_x  = s[3];
        imu_gyro_y  = s[4];
        imu_gyro_z  = s[5];
        #1;
        if (fifo_wr_en === 1'b1) dut_writes++;
        chk("wr_en", 64'(fifo_wr_en), 64'((exp_q.size() > 0) && !f));
        if (exp_q.size() > 0) chk("data", fifo_data_in, exp_q[0]);
        else                  chk("data_idle", fifo_data_in, 64'h0);
        chk("busy", 64'(busy), 64'(exp_q.size() > 0));
        chk("seq", 64'(seq_num), 64'(mseq));
        chk("drops", 64'(drop_count), 64'(mdrop));
    endtask

    task automatic advance();
        bit in_flight;
        in_flight = (exp_q.size() > 0);
        if (clr_drop) mdrop = 16'h0;
        else if (imu_valid && in_flight && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
        if (imu_valid && !in_flight) begin
            mseq = mseq + 8'd1;
            exp_q.push_back({8'hA5, mseq, mts});
            exp_q.push_back({s[0], s[1], s[2], 16'h0000});
            exp_q.push_back({s[3], s[4], s[5], 16'h0000});
        end else if (in_flight && !fifo_full) begin
            void'(exp_q.pop_front());
        end
        mts = mts + 48'd1;
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic f, input logic c);
        drive(v, f, c);
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
        chk("rst_data", fifo_data_in, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_seq", 64'(seq_num), 64'h0);
        chk("rst_drops", 64'(drop_count), 64'h0);
        exp_q.delete();
        mseq  = 8'h0;
        mdrop = 16'h0;
        mts   = 48'h0;
        imu_valid = 1'b0;
        fifo_full = 1'b0;
        clr_drop  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int accepted;
        rst_n     = 1'b1;
        rand_samp = 1'b0;
        foreach (s[i]) s[i] = 16'h0;
        imu_valid = 1'b0;
        fifo_full = 1'b0;
        clr_drop  = 1'b0;
        #2;
        do_reset();

        // Single sample strobed at ts=10
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) s[i] = 16'(i + 1);
        step(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("hdr_word", fifo_data_in, 64'hA501_0000_0000_000A);
        advance();
        drive(1'b0, 1'b0, 1'b0);
        chk("acc_word", fifo_data_in, 64'h0001_0002_0003_0000);
        advance();
        drive(1'b0, 1'b0, 1'b0);
        chk("gyr_word", fifo_data_in, 64'h0004_0005_0006_0000);
        advance();
        step(1'b0, 1'b0, 1'b0);

        // FIFO full for five cycles while the accel word is pending
        for (int i = 0; i < 6; i++) s[i] = 16'(i + 7);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk("full_hold_wr", 64'(fifo_wr_en), 64'h0);
            chk("full_hold_data", fifo_data_in, 64'h0007_0008_0009_0000);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("acc_after_full", fifo_data_in, 64'h0007_0008_0009_0000);
        chk("acc_after_full_wr", 64'(fifo_wr_en), 64'h1);
        advance();
        drain();

        // Strobes every other cycle: half accepted, half dropped
        do_reset();
        dut_writes = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        drain();
        chk("alt_seq", 64'(seq_num), 64'd4);
        chk("alt_drops", 64'(drop_count), 64'd4);
        chk("alt_writes", 64'(dut_writes), 64'd12);

        // Randomized traffic with back-pressure and occasional clears
        rand_samp = 1'b1;
        for (int i = 0; i < 500; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 31) == 0));
        drain();

        // 256 accepted samples wrap the sequence number
        do_reset();
        accepted = 0;
        for (int i = 0; i < 4000 && accepted < 256; i++) begin
            if (exp_q.size() == 0) begin
                accepted++;
                step(1'b1, 1'b0, 1'b0);
            end else begin
                step(1'b0, 1'b0, 1'b0);
            end
        end
        drain();
        chk("wrap_count", 64'(accepted), 64'd256);
        chk("wrap_seq", 64'(seq_num), 64'h00);

        // Drop counter saturation, then clear racing a drop
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 1'b0);
        chk("drop_sat", 64'(drop_count), 64'hFFFF);
        step(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("drop_clr", 64'(drop_count), 64'h0);
        advance();
        drain();

        // Reset while the accel word is pending abandons the packet
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0);
        chk("post_rst_hdr", fifo_data_in, 64'hA501_0000_0000_0000);
        advance();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
